// File: rtl/mmio_init_pkg.sv
// Shared types and constants for the MMIO initiator: FSM state encoding,
// the CCI-P request length code and the standard AFU CSR addresses.
package mmio_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESULT   = 2'd3
  } t_mmio_init_state;

  localparam logic [1:0] MMIO_LEN_8B = 2'b01;

  localparam int MMIO_TID_W_DFLT = 9;

  // AFU CSR addresses, in 4-byte units
  localparam logic [15:0] CSR_ADDR_DFH       = 16'h0000;
  localparam logic [15:0] CSR_ADDR_ID_L      = 16'h0002;
  localparam logic [15:0] CSR_ADDR_ID_H      = 16'h0004;
  localparam logic [15:0] CSR_ADDR_USER_BASE = 16'h0020;

endpackage

// File: rtl/mmio_initiator.sv
// Host-side MMIO requester: issues one 64-bit MMIO read/write at a time into an
// AFU, matches the c2 read response by TID, and reports timeouts and strays.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | cmd_ready high, waiting for a command
// ISSUE    | one-cycle mmio_wr_valid / mmio_rd_valid pulse on the bus
// WAIT_RSP | read outstanding, timeout counter running
// RESULT   | misaligned command rejected, result pulse on the outputs
module mmio_initiator
  import mmio_init_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int TID_W       = MMIO_TID_W_DFLT,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [15:0]          cmd_addr,
  input  logic [63:0]          cmd_wdata,

  output logic                 mmio_wr_valid,
  output logic                 mmio_rd_valid,
  output logic [15:0]          mmio_addr,
  output logic [1:0]           mmio_length,
  output logic [TID_W-1:0]     mmio_tid,
  output logic [63:0]          mmio_data,

  input  logic                 rsp_valid,
  input  logic [TID_W-1:0]     rsp_tid,
  input  logic [63:0]          rsp_data,

  output logic                 res_valid,
  output logic [63:0]          res_data,
  output logic                 res_timeout,
  output logic                 res_misalign,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int             TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  t_mmio_init_state     state_q, state_d;
  logic                 mmio_wr_valid_q, mmio_wr_valid_d;
  logic                 mmio_rd_valid_q, mmio_rd_valid_d;
  logic [15:0]          mmio_addr_q, mmio_addr_d;
  logic [TID_W-1:0]     mmio_tid_q, mmio_tid_d;
  logic [63:0]          mmio_data_q, mmio_data_d;
  logic [TID_W-1:0]     tid_ctr_q, tid_ctr_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [63:0]          res_data_q, res_data_d;
  logic                 res_timeout_q, res_timeout_d;
  logic                 res_misalign_q, res_misalign_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 rsp_match;

  // mmio_tid_q keeps the TID of the outstanding read while waiting
  assign rsp_match = rsp_valid && (state_q == ST_WAIT_RSP) && (rsp_tid == mmio_tid_q);

  always_comb begin
    state_d         = state_q;
    mmio_wr_valid_d = 1'b0;
    mmio_rd_valid_d = 1'b0;
    mmio_addr_d     = mmio_addr_q;
    mmio_tid_d      = mmio_tid_q;
    mmio_data_d     = mmio_data_q;
    tid_ctr_d       = tid_ctr_q;
    to_cnt_d        = to_cnt_q;
    res_valid_d     = 1'b0;
    res_data_d      = res_data_q;
    res_timeout_d   = res_timeout_q;
    res_misalign_d  = res_misalign_q;
    err_cnt_d       = err_cnt_q;

    if (rsp_valid && !rsp_match && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[0]) begin
            state_d        = ST_RESULT;
            res_valid_d    = 1'b1;
            res_data_d     = '0;
            res_timeout_d  = 1'b0;
            res_misalign_d = 1'b1;
          end else begin
            state_d         = ST_ISSUE;
            mmio_wr_valid_d = cmd_write;
            mmio_rd_valid_d = !cmd_write;
            mmio_addr_d     = cmd_addr;
            mmio_data_d     = cmd_write ? cmd_wdata : '0;
            mmio_tid_d      = tid_ctr_q;
          end
        end
      end

      ST_ISSUE: begin
        if (mmio_wr_valid_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_WAIT_RSP;
          tid_ctr_d = tid_ctr_q + TID_W'(1);
          to_cnt_d  = '0;
        end
      end

      ST_WAIT_RSP: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rsp_match) begin
          state_d        = ST_IDLE;
          res_valid_d    = 1'b1;
          res_data_d     = rsp_data;
          res_timeout_d  = 1'b0;
          res_misalign_d = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d        = ST_IDLE;
          res_valid_d    = 1'b1;
          res_data_d     = '0;
          res_timeout_d  = 1'b1;
          res_misalign_d = 1'b0;
        end
      end

      ST_RESULT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mmio_wr_valid_q <= 1'b0;
      mmio_rd_valid_q <= 1'b0;
      mmio_addr_q     <= '0;
      mmio_tid_q      <= '0;
      mmio_data_q     <= '0;
      tid_ctr_q       <= '0;
      to_cnt_q        <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_timeout_q   <= 1'b0;
      res_misalign_q  <= 1'b0;
      err_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      mmio_wr_valid_q <= mmio_wr_valid_d;
      mmio_rd_valid_q <= mmio_rd_valid_d;
      mmio_addr_q     <= mmio_addr_d;
      mmio_tid_q      <= mmio_tid_d;
      mmio_data_q     <= mmio_data_d;
      tid_ctr_q       <= tid_ctr_d;
      to_cnt_q        <= to_cnt_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_timeout_q   <= res_timeout_d;
      res_misalign_q  <= res_misalign_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign mmio_wr_valid = mmio_wr_valid_q;
  assign mmio_rd_valid = mmio_rd_valid_q;
  assign mmio_addr     = mmio_addr_q;
  assign mmio_length   = MMIO_LEN_8B;
  assign mmio_tid      = mmio_tid_q;
  assign mmio_data     = mmio_data_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_timeout   = res_timeout_q;
  assign res_misalign  = res_misalign_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Bench for mmio_initiator: an AFU stub backed by a sparse register memory,
// directed vectors from a table, a reset-abort sequence, TID wrap and random traffic.
module tb_mmio_initiator;
  import mmio_init_pkg::*;

  localparam int TO = 16;
  localparam int TW = 9;
  localparam int EW = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [15:0]   cmd_addr;
  logic [63:0]   cmd_wdata;
  logic          mmio_wr_valid, mmio_rd_valid;
  logic [15:0]   mmio_addr;
  logic [1:0]    mmio_length;
  logic [TW-1:0] mmio_tid;
  logic [63:0]   mmio_data;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic [63:0]   rsp_data;
  logic          res_valid;
  logic [63:0]   res_data;
  logic          res_timeout, res_misalign;
  logic [EW-1:0] err_cnt;

  mmio_initiator #(.TIMEOUT_CYC(TO), .TID_W(TW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_length(mmio_length), .mmio_tid(mmio_tid),
    .mmio_data(mmio_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .res_valid(res_valid), .res_data(res_data), .res_timeout(res_timeout),
    .res_misalign(res_misalign), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_tid = 0;
  int exp_err = 0;
  logic [63:0] mem [int];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wd;
    int          delay;     // response delay after the request cycle; >TO means too late
    bit          wrong;     // a wrong-TID response precedes the real one
    logic [63:0] exp_data;
    bit          exp_to;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] stub_read(input int a);
    if (mem.exists(a)) return mem[a];
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                         input int delay, input bit wrong,
                         input logic [63:0] exp_data, input bit exp_to);
    logic [TW-1:0] tid;
    int exp_cyc;
    check("ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
    cmd_wdata = {$urandom, $urandom};
    if (addr[0]) begin
      check("misalign_valid", 64'(res_valid), 64'(1));
      check("misalign_flag", 64'(res_misalign), 64'(1));
      check("misalign_to", 64'(res_timeout), 64'(0));
      check("misalign_data", res_data, 64'(0));
      check("misalign_nobus", 64'({mmio_wr_valid, mmio_rd_valid}), 64'(0));
      check("misalign_busy", 64'(cmd_ready), 64'(0));
      step();
      check("misalign_pulse", 64'(res_valid), 64'(0));
      check("misalign_ready", 64'(cmd_ready), 64'(1));
      check("misalign_nobus2", 64'({mmio_wr_valid, mmio_rd_valid}), 64'(0));
      return;
    end
    tid = TW'(exp_tid);
    check("issue_wr_valid", 64'(mmio_wr_valid), 64'(wr));
    check("issue_rd_valid", 64'(mmio_rd_valid), 64'(!wr));
    check("issue_addr", 64'(mmio_addr), 64'(addr));
    check("issue_tid", 64'(mmio_tid), 64'(tid));
    check("issue_data", mmio_data, wr ? wd : 64'(0));
    check("issue_len", 64'(mmio_length), 64'(1));
    if (wr) begin
      mem[int'(addr)] = wd;
      step();
      check("wr_ready", 64'(cmd_ready), 64'(1));
      check("wr_single", 64'(mmio_wr_valid), 64'(0));
      check("wr_no_res", 64'(res_valid), 64'(0));
      return;
    end
    exp_tid = (exp_tid + 1) % (1 << TW);
    exp_cyc = exp_to ? TO + 1 : delay + 1;
    for (int c = 1; c <= exp_cyc; c++) begin
      rsp_valid = 1'b0; rsp_tid = TW'($urandom); rsp_data = {$urandom, $urandom};
      if (c - 1 == delay) begin
        rsp_valid = 1'b1; rsp_tid = tid; rsp_data = stub_read(int'(addr));
      end else if (wrong && delay >= 2 && c - 1 == delay - 1) begin
        rsp_valid = 1'b1; rsp_tid = tid ^ TW'(1);
        exp_err++;
      end
      step();
      rsp_valid = 1'b0;
      if (c < exp_cyc) begin
        check("rd_wait_no_res", 64'(res_valid), 64'(0));
        check("rd_wait_busy", 64'(cmd_ready), 64'(0));
        check("rd_single", 64'(mmio_rd_valid), 64'(0));
      end else begin
        check("rd_res_valid", 64'(res_valid), 64'(1));
        check("rd_res_data", res_data, exp_data);
        check("rd_res_timeout", 64'(res_timeout), 64'(exp_to));
        check("rd_res_misalign", 64'(res_misalign), 64'(0));
        check("rd_ready", 64'(cmd_ready), 64'(1));
        check("rd_err_cnt", 64'(err_cnt), 64'(exp_err));
      end
    end
    step();
    check("rd_pulse_one", 64'(res_valid), 64'(0));
  endtask

  task automatic stray_idle();
    rsp_valid = 1'b1; rsp_tid = TW'($urandom); rsp_data = {$urandom, $urandom};
    step();
    rsp_valid = 1'b0;
    exp_err++;
    check("stray_err_cnt", 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] old_tid;
    int seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
    mem[int'(CSR_ADDR_ID_L)] = 64'h0123_4567_89AB_CDEF;
    step(); step(); step();
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_mmio_valid", 64'({mmio_wr_valid, mmio_rd_valid}), 64'(0));
    check("rst_mmio_addr", 64'(mmio_addr), 64'(0));
    check("rst_mmio_tid", 64'(mmio_tid), 64'(0));
    check("rst_mmio_data", mmio_data, 64'(0));
    check("rst_mmio_len", 64'(mmio_length), 64'(1));
    check("rst_res", 64'({res_valid, res_timeout, res_misalign}), 64'(0));
    check("rst_res_data", res_data, 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    rst = 1'b0;
    step();

    tbl.push_back('{0, 16'h0002, 64'h0, 2, 0, 64'h0123_4567_89AB_CDEF, 0});
    tbl.push_back('{1, 16'h0020, 64'hDEAD_BEEF, 0, 0, 64'h0, 0});
    tbl.push_back('{0, 16'h0020, 64'h0, 2, 0, 64'hDEAD_BEEF, 0});
    tbl.push_back('{0, 16'h0004, 64'h0, 99, 0, 64'h0, 1});
    tbl.push_back('{0, 16'h0020, 64'h0, 3, 1, 64'hDEAD_BEEF, 0});
    tbl.push_back('{0, 16'h0021, 64'h0, 2, 0, 64'h0, 0});
    tbl.push_back('{1, 16'h0023, 64'h1, 0, 0, 64'h0, 0});
    tbl.push_back('{1, 16'h0024, 64'hCAFE_F00D_1234_5678, 0, 0, 64'h0, 0});
    tbl.push_back('{0, 16'h0024, 64'h0, TO, 0, 64'hCAFE_F00D_1234_5678, 0});
    tbl.push_back('{0, 16'h0024, 64'h0, TO + 1, 1, 64'h0, 1});
    tbl.push_back('{0, 16'h0000, 64'h0, 1, 0, 64'hA5A5_0000_0000_0000, 0});
    tbl.push_back('{0, 16'h0023, 64'h0, 1, 0, 64'h0, 0});
    foreach (tbl[i])
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].delay, tbl[i].wrong,
              tbl[i].exp_data, tbl[i].exp_to);
    stray_idle();

    // Reset in the middle of an outstanding read
    old_tid = TW'(exp_tid);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_tid = 0; exp_err = 0;
    check("rstmid_ready", 64'(cmd_ready), 64'(1));
    check("rstmid_no_res", 64'(res_valid), 64'(0));
    check("rstmid_tid", 64'(mmio_tid), 64'(0));
    check("rstmid_err", 64'(err_cnt), 64'(0));
    seen = 0;
    for (int c = 0; c < TO + 4; c++) begin
      step();
      if (res_valid) seen++;
    end
    check("rstmid_never_res", 64'(seen), 64'(0));
    rsp_valid = 1'b1; rsp_tid = old_tid; rsp_data = 64'h5555;
    step();
    rsp_valid = 1'b0;
    exp_err = 1;
    check("rstmid_late_stray", 64'(err_cnt), 64'(1));
    check("rstmid_late_no_res", 64'(res_valid), 64'(0));

    // TID sequence 0..2^TW-1 then wraps to 0
    for (int i = 0; i <= (1 << TW); i++) begin
      int a;
      a = 2 * int'($urandom_range(0, 31));
      run_cmd(0, 16'(a), 64'h0, int'($urandom_range(1, 3)), 0, stub_read(a), 0);
    end

    for (int i = 0; i < 80; i++) begin
      bit wr, wrong, odd;
      int a, d;
      logic [63:0] wd;
      wr = ($urandom_range(0, 2) == 0);
      odd = ($urandom_range(0, 5) == 0);
      a = 2 * int'($urandom_range(0, 31)) + (odd ? 1 : 0);
      d = int'($urandom_range(1, TO + 4));
      wrong = ($urandom_range(0, 3) == 0);
      wd = {$urandom, $urandom};
      if (d > TO) run_cmd(wr, 16'(a), wd, d, wrong, 64'h0, 1);
      else        run_cmd(wr, 16'(a), wd, d, wrong, stub_read(a), 0);
      if ($urandom_range(0, 7) == 0) stray_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
